log_spectrum_sequencer: RTL and testbench

LOG_SPECTRUM_SEQUENCER -- requirements
Module: log_spectrum_sequencer

---
 rtl/log_spectrum_sequencer.sv | 91 +++++++++
 tb/tb_log_spectrum_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/log_spectrum_sequencer.sv
// log_spectrum_sequencer: reads each spectrum bin, passes it through an external log unit, streams the results.
// Ports: clk/rst (sync active-high), start -> busy/done frame control,
//        mem_rd_en/mem_addr/mem_rd_data bin memory read (1-cycle latency),
//        mem_wr_en/mem_wr_data bin write-back, log_raw/log_res external log unit,
//        out_valid/out_ready/out_data/out_addr/out_last result stream.
// Option: define LOG_SEQ_CLEAR_ON_READ_EN to zero each bin in memory after it is read.
module log_spectrum_sequencer #(
    parameter int N_BINS = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [19:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [19:0]       mem_wr_data,
    output logic [19:0]       log_raw,
    input  logic [7:0]        log_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, LOG, OUT} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q;
    logic [19:0]       raw_q;
    logic [7:0]        data_q;
    logic              done_q;
    logic              at_last;
    assign at_last = cnt_q == LAST;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = READ;
                cnt_d   = '0;
            end
            READ: state_d = WAIT;
            WAIT: state_d = LOG;
            LOG:  state_d = OUT;
            OUT:  if (out_ready) begin
                state_d = at_last ? IDLE : READ;
                cnt_d   = at_last ? cnt_q : cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raw_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == WAIT) raw_q <= mem_rd_data;
            if (state_q == LOG) begin
                data_q <= log_res;
                addr_q <= cnt_q;
            end
            done_q <= state_q == OUT && out_ready && at_last;
        end
    end
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign mem_rd_en   = state_q == READ;
    assign mem_wr_data = '0;
`ifdef LOG_SEQ_CLEAR_ON_READ_EN
    assign mem_wr_en   = state_q == WAIT;
    assign mem_addr    = (mem_rd_en || mem_wr_en) ? cnt_q : '0;
`else
    assign mem_wr_en   = 1'b0;
    assign mem_addr    = mem_rd_en ? cnt_q : '0;
`endif
    assign log_raw     = raw_q;
    assign out_valid   = state_q == OUT;
    assign out_data    = data_q;
    assign out_addr    = addr_q;
    assign out_last    = out_valid && addr_q == LAST;
endmodule

// File: tb/tb_log_spectrum_sequencer.sv
// tb_log_spectrum_sequencer: directed checks of the log spectrum sequencer with a 4-bin memory model.
module tb_log_spectrum_sequencer;
    localparam int N = 4;
    localparam int AW = 2;
`ifdef LOG_SEQ_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    logic          clk = 1'b0, rst, start, out_ready, load;
    logic          busy, done, mem_rd_en, mem_wr_en, out_valid, out_last;
    logic [AW-1:0] mem_addr, out_addr;
    logic [19:0]   mem_rd_data, mem_wr_data, log_raw;
    logic [7:0]    log_res, out_data;
    logic [19:0]   mem [N];
    logic [19:0]   vals [N] = '{20'd0, 20'd1, 20'd5, 20'd255};
    logic [7:0]    exps [N] = '{8'd0, 8'd1, 8'd3, 8'd8};
    int            total = 0, bad = 0, wr_cnt = 0;

    log_spectrum_sequencer #(.N_BINS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .log_raw(log_raw), .log_res(log_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Golden log unit: bit length of the operand (0 -> 0).
    function automatic logic [7:0] blen(input logic [19:0] x);
        blen = 8'd0;
        for (int i = 0; i < 20; i++) if (x[i]) blen = 8'(i + 1);
    endfunction
    assign log_res = blen(log_raw);

    always @(posedge clk) begin
        if (load) for (int i = 0; i < N; i++) mem[i] <= vals[i];
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reload;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " rd_en"}, mem_rd_en, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " wr_en"}, mem_wr_en, 0);
        check({tag, " wr_data"}, mem_wr_data, 0);
        check({tag, " valid"}, out_valid, 0);
        check({tag, " data"}, out_data, 0);
        check({tag, " out_addr"}, out_addr, 0);
        check({tag, " last"}, out_last, 0);
        check({tag, " log_raw"}, log_raw, 0);
    endtask

    // Starts a frame from "#1 after an edge" and walks it cycle by cycle.
    // Returns in the done cycle, or right after the reset when rst_bin is hit.
    task automatic run_frame(input int stall_bin, input int rst_bin, input bit hold, input bit zero);
        logic [19:0] raw;
        logic [7:0]  ed;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int b = 0; b < N; b++) begin
            raw = zero ? 20'd0 : vals[b];
            ed  = zero ? 8'd0 : exps[b];
            check($sformatf("read%0d rd_en", b), mem_rd_en, 1);
            check($sformatf("read%0d addr", b), mem_addr, b);
            check($sformatf("read%0d busy", b), busy, 1);
            tick();
            check($sformatf("wait%0d rd_en", b), mem_rd_en, 0);
            check($sformatf("wait%0d wr_en", b), mem_wr_en, CLR);
            check($sformatf("wait%0d addr", b), mem_addr, CLR ? b : 0);
            tick();
            check($sformatf("log%0d raw", b), log_raw, raw);
            check($sformatf("log%0d valid", b), out_valid, 0);
            tick();
            check($sformatf("out%0d valid", b), out_valid, 1);
            check($sformatf("out%0d data", b), out_data, ed);
            check($sformatf("out%0d addr", b), out_addr, b);
            check($sformatf("out%0d last", b), out_last, b == N - 1);
            check($sformatf("out%0d done", b), done, 0);
            if (b == rst_bin) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_zero("midrst");
                return;
            end
            if (b == stall_bin) begin
                out_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    check($sformatf("stall%0d valid", s), out_valid, 1);
                    check($sformatf("stall%0d data", s), out_data, ed);
                    check($sformatf("stall%0d addr", s), out_addr, b);
                    check($sformatf("stall%0d rd_en", s), mem_rd_en, 0);
                    check($sformatf("stall%0d wr_en", s), mem_wr_en, 0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check("end done", done, 1);
        check("end busy", busy, 0);
        check("end valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        load = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle");
        reload();
        run_frame(-1, -1, 1'b0, 1'b0);
        check("wr count", wr_cnt, CLR ? N : 0);
        for (int i = 0; i < N; i++) check($sformatf("mem%0d after", i), mem[i], CLR ? 20'd0 : vals[i]);
        tick();
        check("post done", done, 0);
        check("post busy", busy, 0);
        reload();
        run_frame(2, -1, 1'b0, 1'b0);
        reload();
        run_frame(-1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after rst done", done, 0);
            check("after rst busy", busy, 0);
        end
        reload();
        run_frame(-1, -1, 1'b0, 1'b0);
        reload();
        run_frame(-1, -1, 1'b1, 1'b0);
        run_frame(-1, -1, 1'b0, CLR);
        tick();
        check("final done", done, 0);
        check("final busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
